// File: rtl/fmul_result_packer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fmul_result_packer_if
//  Description : Handshake bundle between the normaliser, the result packer
//                and the result consumer.
//                  in_*  : normalised result from upstream (valid/ready)
//                  out_* : packed result at the FIFO head (valid/ready)
//                master = producer/consumer side, slave = packer.
//  Revision    : 1.0  initial release
// ============================================================================
interface fmul_result_packer_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [8:0]  in_exp;
    logic [15:0] in_mantissa;
    logic        in_guard;
    logic        in_sticky;
    logic        in_zero;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic        out_ovf;
    logic        out_unf;

    modport master (
        output in_valid, in_sign, in_exp, in_mantissa, in_guard, in_sticky,
               in_zero, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, out_unf
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mantissa, in_guard, in_sticky,
               in_zero, out_ready,
        output in_ready, out_valid, out_data, out_ovf, out_unf
    );
endinterface
`default_nettype wire

// File: rtl/fmul_result_packer.sv
`default_nettype none
// ============================================================================
//  Module      : fmul_result_packer
//  Description : Final stage of the 24-bit float multiplier. Rounds the
//                normalised mantissa to nearest-even, classifies
//                zero/underflow/overflow, packs {sign, exp[6:0], frac[15:0]}
//                (bias 63) and queues the result in a small FIFO.
//                Saturating counters track accepted overflow/underflow events.
//  Ports       : clk      - clock, rising edge
//                rst      - asynchronous reset, active low
//                bus      - in_*/out_* handshake bundle (slave side)
//                clr_cnt  - synchronous clear of both event counters
//                ovf_cnt  - accepted overflow events (saturating)
//                unf_cnt  - accepted underflow events (saturating)
//  Revision    : 1.0  initial release
// ============================================================================
module fmul_result_packer #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    fmul_result_packer_if.slave   bus,
    input  wire logic             clr_cnt,
    output logic [CNT_W-1:0]      ovf_cnt,
    output logic [CNT_W-1:0]      unf_cnt
);

    localparam int c_ptr_w   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_occ_w   = $clog2(DEPTH + 1);
    localparam int c_entry_w = 26;   // {ovf, unf, data[23:0]}

    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(DEPTH - 1);
    localparam logic [c_occ_w-1:0] c_full_occ = c_occ_w'(DEPTH);

    // ------------------------------------------------------------------
    // Rounding and classification (combinational, written on accept)
    // ------------------------------------------------------------------
    logic               w_inc;
    logic [16:0]        w_sum;
    logic signed [9:0]  w_e;
    logic [23:0]        w_data;
    logic               w_ovf;
    logic               w_unf;

    always_comb begin
        w_inc  = bus.in_guard & (bus.in_sticky | bus.in_mantissa[0]);
        w_sum  = {1'b0, bus.in_mantissa} + {16'd0, w_inc};
        // One extra bit of headroom: 255 + carry must not wrap negative.
        w_e    = $signed({bus.in_exp[8], bus.in_exp}) + $signed({9'd0, w_sum[16]});
        w_data = '0;
        w_ovf  = 1'b0;
        w_unf  = 1'b0;
        if (bus.in_zero) begin
            w_data = {bus.in_sign, 23'd0};
        end else if (w_e <= 10'sd0) begin
            w_data = {bus.in_sign, 23'd0};
            w_unf  = 1'b1;
        end else if (w_e >= 10'sd127) begin
            // Exponent 127 is reserved as the saturation code.
            w_data = {bus.in_sign, 7'd127, 16'd0};
            w_ovf  = 1'b1;
        end else begin
            // On mantissa carry-out w_sum[15:0] is already zero.
            w_data = {bus.in_sign, w_e[6:0], w_sum[15:0]};
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO and counters
    // ------------------------------------------------------------------
    logic [c_entry_w-1:0] mem_q [DEPTH];
    logic [c_entry_w-1:0] mem_d [DEPTH];
    logic [c_ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_occ_w-1:0]   occ_q, occ_d;
    logic [CNT_W-1:0]     ovf_cnt_q, ovf_cnt_d;
    logic [CNT_W-1:0]     unf_cnt_q, unf_cnt_d;

    logic w_in_ready;
    logic w_out_valid;
    logic w_push;
    logic w_pop;

    // Ready is gated by rst so upstream never sees a slot while in reset.
    assign w_in_ready  = rst & (occ_q != c_full_occ);
    assign w_out_valid = (occ_q != '0);
    assign w_push      = bus.in_valid & w_in_ready;
    assign w_pop       = w_out_valid & bus.out_ready;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;
        ovf_cnt_d = ovf_cnt_q;
        unf_cnt_d = unf_cnt_q;

        if (w_push) begin
            mem_d[wr_ptr_q] = {w_ovf, w_unf, w_data};
            wr_ptr_d = (wr_ptr_q == c_last_ptr) ? '0 : wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = (rd_ptr_q == c_last_ptr) ? '0 : rd_ptr_q + 1'b1;
        end
        occ_d = occ_q + c_occ_w'(w_push) - c_occ_w'(w_pop);

        // Counters track accepts, not pops; clear wins over increment.
        if (clr_cnt) begin
            ovf_cnt_d = '0;
            unf_cnt_d = '0;
        end else begin
            if (w_push && w_ovf && (ovf_cnt_q != '1)) begin
                ovf_cnt_d = ovf_cnt_q + 1'b1;
            end
            if (w_push && w_unf && (unf_cnt_q != '1)) begin
                unf_cnt_d = unf_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            ovf_cnt_q <= '0;
            unf_cnt_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            ovf_cnt_q <= ovf_cnt_d;
            unf_cnt_q <= unf_cnt_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign {bus.out_ovf, bus.out_unf, bus.out_data} = mem_q[rd_ptr_q];
    assign ovf_cnt = ovf_cnt_q;
    assign unf_cnt = unf_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fmul_result_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fmul_result_packer
//  Description : Directed self-checking bench for fmul_result_packer
//                (DEPTH=2, CNT_W=8) with hand-computed expected words.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fmul_result_packer;

    logic       clk;
    logic       rst;
    logic       clr_cnt;
    logic [7:0] ovf_cnt;
    logic [7:0] unf_cnt;
    int         total;
    int         bad;

    fmul_result_packer_if bus_if ();

    fmul_result_packer #(.DEPTH(2), .CNT_W(8)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_if.slave),
        .clr_cnt (clr_cnt),
        .ovf_cnt (ovf_cnt),
        .unf_cnt (unf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic s, input logic [8:0] e, input logic [15:0] m,
                         input logic g, input logic st, input logic z);
        bus_if.in_sign     = s;
        bus_if.in_exp      = e;
        bus_if.in_mantissa = m;
        bus_if.in_guard    = g;
        bus_if.in_sticky   = st;
        bus_if.in_zero     = z;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One word through an empty FIFO with the consumer ready.
    task automatic xfer(input string tag, input logic [23:0] d,
                        input logic ovf, input logic unf);
        bus_if.in_valid  = 1'b1;
        bus_if.out_ready = 1'b1;
        chk({tag, "_rdy"}, 32'(bus_if.in_ready), 32'd1);
        tick();
        bus_if.in_valid = 1'b0;
        chk({tag, "_vld"},  32'(bus_if.out_valid), 32'd1);
        chk({tag, "_data"}, 32'(bus_if.out_data), 32'(d));
        chk({tag, "_ovf"},  32'(bus_if.out_ovf), 32'(ovf));
        chk({tag, "_unf"},  32'(bus_if.out_unf), 32'(unf));
        tick();
        chk({tag, "_empty"}, 32'(bus_if.out_valid), 32'd0);
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        rst              = 1'b0;
        clr_cnt          = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        drive(1'b0, 9'd0, 16'h0, 1'b0, 1'b0, 1'b0);

        // Reset state
        #2;
        chk("rst_in_ready",  32'(bus_if.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus_if.out_data), 32'd0);
        chk("rst_flags",     32'({bus_if.out_ovf, bus_if.out_unf}), 32'd0);
        chk("rst_ovf_cnt",   32'(ovf_cnt), 32'd0);
        chk("rst_unf_cnt",   32'(unf_cnt), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rel_in_ready", 32'(bus_if.in_ready), 32'd1);
        tick();

        // Main function
        drive(1'b0, 9'd63, 16'h0000, 1'b0, 1'b0, 1'b0);
        xfer("one", 24'h3F0000, 1'b0, 1'b0);
        drive(1'b0, 9'd63, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        xfer("carry", 24'h400000, 1'b0, 1'b0);
        drive(1'b0, 9'd63, 16'h0002, 1'b1, 1'b0, 1'b0);
        xfer("tie_even", 24'h3F0002, 1'b0, 1'b0);
        drive(1'b0, 9'd63, 16'h0002, 1'b1, 1'b1, 1'b0);
        xfer("round_up", 24'h3F0003, 1'b0, 1'b0);
        drive(1'b1, 9'd126, 16'hFFFF, 1'b1, 1'b1, 1'b0);
        xfer("ovf_carry", 24'hFF0000, 1'b1, 1'b0);
        chk("ovf_cnt_1", 32'(ovf_cnt), 32'd1);
        drive(1'b1, 9'h1FB, 16'h1234, 1'b0, 1'b0, 1'b0);   // E = -5
        xfer("unf_neg", 24'h800000, 1'b0, 1'b1);
        chk("unf_cnt_1", 32'(unf_cnt), 32'd1);
        drive(1'b0, 9'd200, 16'h5555, 1'b1, 1'b1, 1'b1);
        xfer("zero", 24'h000000, 1'b0, 1'b0);
        chk("zero_ovf_cnt", 32'(ovf_cnt), 32'd1);
        chk("zero_unf_cnt", 32'(unf_cnt), 32'd1);

        // Exponent boundaries
        drive(1'b0, 9'd0, 16'h1234, 1'b0, 1'b0, 1'b0);
        xfer("e0_unf", 24'h000000, 1'b0, 1'b1);
        drive(1'b0, 9'd0, 16'hFFFF, 1'b1, 1'b1, 1'b0);     // rounds up to E=1
        xfer("e0_carry", 24'h010000, 1'b0, 1'b0);
        drive(1'b0, 9'd1, 16'h1234, 1'b0, 1'b1, 1'b0);
        xfer("e1", 24'h011234, 1'b0, 1'b0);
        drive(1'b0, 9'd126, 16'h0000, 1'b0, 1'b0, 1'b0);
        xfer("e126", 24'h7E0000, 1'b0, 1'b0);
        drive(1'b0, 9'd127, 16'h0000, 1'b0, 1'b0, 1'b0);
        xfer("e127_ovf", 24'h7F0000, 1'b1, 1'b0);
        drive(1'b0, 9'd255, 16'hFFFF, 1'b1, 1'b1, 1'b0);   // 256 must not wrap
        xfer("e255_ovf", 24'h7F0000, 1'b1, 1'b0);
        chk("bnd_ovf_cnt", 32'(ovf_cnt), 32'd3);
        chk("bnd_unf_cnt", 32'(unf_cnt), 32'd2);

        // Backpressure: A, B fill the FIFO, C is held
        bus_if.out_ready = 1'b0;
        bus_if.in_valid  = 1'b1;
        drive(1'b0, 9'd10, 16'h0001, 1'b0, 1'b0, 1'b0);    // A = 0x0A0001
        chk("bp_rdy_a", 32'(bus_if.in_ready), 32'd1);
        tick();
        drive(1'b0, 9'd11, 16'h0002, 1'b0, 1'b0, 1'b0);    // B = 0x0B0002
        chk("bp_rdy_b", 32'(bus_if.in_ready), 32'd1);
        tick();
        drive(1'b0, 9'd12, 16'h0003, 1'b0, 1'b0, 1'b0);    // C = 0x0C0003
        chk("bp_full",   32'(bus_if.in_ready), 32'd0);
        chk("bp_head_a", 32'(bus_if.out_data), 32'h0A0001);
        tick();
        chk("bp_hold_rdy",  32'(bus_if.in_ready), 32'd0);
        chk("bp_hold_data", 32'(bus_if.out_data), 32'h0A0001);
        chk("bp_hold_vld",  32'(bus_if.out_valid), 32'd1);
        bus_if.out_ready = 1'b1;
        #1;
        chk("bp_full_pop_rdy", 32'(bus_if.in_ready), 32'd0);
        tick();                                            // A pops
        chk("bp_rdy_c",  32'(bus_if.in_ready), 32'd1);
        chk("bp_head_b", 32'(bus_if.out_data), 32'h0B0002);
        tick();                                            // B pops, C pushed
        bus_if.in_valid = 1'b0;
        chk("bp_vld_c",  32'(bus_if.out_valid), 32'd1);
        chk("bp_head_c", 32'(bus_if.out_data), 32'h0C0003);
        tick();                                            // C pops
        chk("bp_drained", 32'(bus_if.out_valid), 32'd0);

        // Counter saturation (3 + 300 overflows) and clear priority
        drive(1'b0, 9'd150, 16'h0000, 1'b0, 1'b0, 1'b0);
        bus_if.in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
        end
        chk("sat_ovf_cnt", 32'(ovf_cnt), 32'd255);
        clr_cnt = 1'b1;
        chk("clr_rdy", 32'(bus_if.in_ready), 32'd1);
        tick();
        clr_cnt         = 1'b0;
        bus_if.in_valid = 1'b0;
        chk("clr_ovf_cnt", 32'(ovf_cnt), 32'd0);
        chk("clr_unf_cnt", 32'(unf_cnt), 32'd0);
        tick();
        tick();
        chk("clr_drained", 32'(bus_if.out_valid), 32'd0);
        drive(1'b1, 9'd130, 16'h0000, 1'b0, 1'b0, 1'b0);
        xfer("post_clr", 24'hFF0000, 1'b1, 1'b0);
        chk("post_clr_cnt", 32'(ovf_cnt), 32'd1);

        // Asynchronous reset with two words queued
        bus_if.out_ready = 1'b0;
        bus_if.in_valid  = 1'b1;
        drive(1'b0, 9'd20, 16'h00AA, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        bus_if.in_valid = 1'b0;
        chk("ar_queued", 32'(bus_if.out_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_vld",     32'(bus_if.out_valid), 32'd0);
        chk("ar_rdy",     32'(bus_if.in_ready), 32'd0);
        chk("ar_data",    32'(bus_if.out_data), 32'd0);
        chk("ar_ovf_cnt", 32'(ovf_cnt), 32'd0);
        tick();
        #2;
        rst              = 1'b1;
        bus_if.out_ready = 1'b1;
        tick();
        tick();
        chk("ar_rel_vld", 32'(bus_if.out_valid), 32'd0);
        chk("ar_rel_rdy", 32'(bus_if.in_ready), 32'd1);
        drive(1'b0, 9'd64, 16'h8000, 1'b1, 1'b0, 1'b0);    // tie, even LSB
        xfer("ar_new", 24'h408000, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
